// File: rtl/clksw_pkg.sv
// Shared definitions for the HS/LS CPU clock switch request side.
// Holds the state encoding, the default dwell/timeout constants and the
// counter-width helper, so RTL, benches and debug decode agree on them.
package clksw_pkg;

  // Debug-visible state encoding; values 5..7 are illegal.
  typedef enum logic [2:0] {
    LS_RUN  = 3'd0,
    HS_REQ  = 3'd1,
    HS_RUN  = 3'd2,
    LS_REQ  = 3'd3,
    LS_HOLD = 3'd4
  } clksw_state_e;

  localparam int HOLD_CYCLES_DEF    = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  // Width of the single counter that serves both the hold and the timeout.
  function automatic int cnt_width(input int hold, input int tmo);
    return $clog2(((hold > tmo) ? hold : tmo) + 1);
  endfunction

endpackage

// File: rtl/clksw_req_ctrl_sync2.sv
// sync2: two-flop synchroniser, async active-low reset to 0.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running on clk.
// Ports: clk (sampling clock), rst_b (async reset, active low),
//        d (asynchronous input), q (synchronised output).
module sync2 (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clksw_req_ctrl.sv
// clksw_req_ctrl: lsclk-side sequencer that requests HS/LS from the clock
// switch, confirms each transition from its acks and flags a stalled switch.
// Latency: outputs registered; HS ack seen 2 cycles late through sync2.
// Backpressure: none; turbo_en/need_slow are levels sampled every cycle.
// Ports:
//   lsclk_in, rst_b    - slow clock, async active-low reset
//   turbo_en           - HS operation permitted
//   need_slow          - current/next access must run on lsclk
//   fault_clr          - pulse, clears fault in LS_RUN/LS_HOLD only
//   hsclk_selected     - switch HS ack (hs domain, synchronised here)
//   lsclk_selected     - switch LS ack (already lsclk registered)
//   hsclk_sel          - request to switch, 1 = HS
//   switching          - transition in flight
//   fault              - sticky, switch failed to acknowledge
//   state_o            - current state, debug
// HOLD_CYCLES must be >= 1 and TIMEOUT_CYCLES must be > 3.
module clksw_req_ctrl
  import clksw_pkg::*;
#(
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       lsclk_in,
  input  logic       rst_b,
  input  logic       turbo_en,
  input  logic       need_slow,
  input  logic       fault_clr,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic       switching,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  clksw_state_e  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          fault_set, fault_nxt;
  logic          hsclk_sel_nxt, switching_nxt;
  logic          hs_sync;
  logic          slow_req;

  sync2 u_hs_sync (
    .clk   (lsclk_in),
    .rst_b (rst_b),
    .d     (hsclk_selected),
    .q     (hs_sync)
  );

  assign slow_req = need_slow | ~turbo_en;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fault_set = 1'b0;
    unique0 case (1'b1) default: ; endcase
    case (state)
      LS_RUN: begin
        if (turbo_en && !need_slow && !fault) begin
          state_nxt = HS_REQ;
          cnt_nxt   = '0;
        end
      end
      HS_REQ: begin
        // A late ack still wins over an abort or a timeout.
        if (hs_sync) begin
          state_nxt = HS_RUN;
          cnt_nxt   = '0;
        end else if (slow_req) begin
          state_nxt = LS_REQ;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          fault_set = 1'b1;
          state_nxt = LS_REQ;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HS_RUN: begin
        // A requested exit masks a coincident ack drop.
        if (slow_req) begin
          state_nxt = LS_REQ;
          cnt_nxt   = '0;
        end else if (!hs_sync) begin
          fault_set = 1'b1;
          state_nxt = LS_REQ;
          cnt_nxt   = '0;
        end
      end
      LS_REQ: begin
        // LS must be confirmed by both acks; without it we wait forever.
        if (lsclk_selected && !hs_sync) begin
          state_nxt = LS_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else if (cnt == TMO_LAST) begin
          fault_set = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      LS_HOLD: begin
        if (cnt == '0) begin
          state_nxt = LS_RUN;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = LS_RUN;
        cnt_nxt   = '0;
      end
    endcase

    // Set beats clear; clearing is only allowed once settled in LS.
    fault_nxt = fault_set |
                (fault & ~(fault_clr & ((state == LS_RUN) | (state == LS_HOLD))));

    hsclk_sel_nxt = (state_nxt == HS_REQ) | (state_nxt == HS_RUN);
    switching_nxt = (state_nxt == HS_REQ) | (state_nxt == LS_REQ);
  end

  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state     <= LS_RUN;
      cnt       <= '0;
      fault     <= 1'b0;
      hsclk_sel <= 1'b0;
      switching <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      fault     <= fault_nxt;
      hsclk_sel <= hsclk_sel_nxt;
      switching <= switching_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_clksw_req_ctrl.sv
// Directed bench for clksw_req_ctrl with a hand-driven switch ack model.
// Cycle k is the interval just after rising edge k; inputs set in cycle k
// are sampled at edge k+1. Observed word is {state_o, hsclk_sel, switching, fault}.
module tb_clksw_req_ctrl;

  logic       lsclk_in = 1'b0;
  logic       rst_b;
  logic       turbo_en, need_slow, fault_clr;
  logic       hsclk_selected, lsclk_selected;
  logic       hsclk_sel, switching, fault;
  logic [2:0] state_o;

  int         vecs = 0;
  int         errs = 0;
  logic [5:0] exp;

  clksw_req_ctrl #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .lsclk_in       (lsclk_in),
    .rst_b          (rst_b),
    .turbo_en       (turbo_en),
    .need_slow      (need_slow),
    .fault_clr      (fault_clr),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .switching      (switching),
    .fault          (fault),
    .state_o        (state_o)
  );

  always #5 lsclk_in = ~lsclk_in;

  task automatic tick();
    @(posedge lsclk_in);
    #1;
  endtask

  // Leaves the bench in cycle 0, LS_RUN, switch parked on LS.
  task automatic do_reset();
    rst_b          = 1'b0;
    turbo_en       = 1'b0;
    need_slow      = 1'b0;
    fault_clr      = 1'b0;
    hsclk_selected = 1'b0;
    lsclk_selected = 1'b1;
    repeat (2) tick();
    rst_b = 1'b1;
  endtask

  // Ideal HS entry: ack one cycle after the request; HS_RUN at cycle 5.
  task automatic go_hs();
    do_reset();
    turbo_en  = 1'b1;
    need_slow = 1'b0;
    tick();
    lsclk_selected = 1'b0;
    tick();
    hsclk_selected = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    exp = 6'b000_000;
    vecs++;
    if ({state_o, hsclk_sel, switching, fault} !== exp) begin
      errs++;
      $display("FAIL reset_state: got %b want %b", {state_o, hsclk_sel, switching, fault}, exp);
    end
    // turbo disabled, then turbo with need_slow: never leave LS_RUN
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) begin
        turbo_en  = 1'b1;
        need_slow = 1'b1;
      end
      tick();
      vecs++;
      if ({state_o, hsclk_sel, switching, fault} !== exp) begin
        errs++;
        $display("FAIL reset_idle c%0d: got %b want %b", c, {state_o, hsclk_sel, switching, fault}, exp);
      end
    end
  endtask

  task automatic test_hs_entry();
    do_reset();
    turbo_en  = 1'b1;
    need_slow = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) lsclk_selected = 1'b0;
      if (c == 2) hsclk_selected = 1'b1;
      exp = (c < 5) ? 6'b001_110 : 6'b010_100;
      vecs++;
      if ({state_o, hsclk_sel, switching, fault} !== exp) begin
        errs++;
        $display("FAIL hs_entry c%0d: got %b want %b", c, {state_o, hsclk_sel, switching, fault}, exp);
      end
    end
  endtask

  task automatic test_return_ls();
    go_hs();
    need_slow = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      tick();
      if (r == 1) begin
        need_slow      = 1'b0;
        hsclk_selected = 1'b0;
      end
      if (r == 3) lsclk_selected = 1'b1;
      if (r <= 3)      exp = 6'b011_010;
      else if (r <= 7) exp = 6'b100_000;
      else if (r == 8) exp = 6'b000_000;
      else             exp = 6'b001_110;
      vecs++;
      if ({state_o, hsclk_sel, switching, fault} !== exp) begin
        errs++;
        $display("FAIL return_ls r%0d: got %b want %b", r, {state_o, hsclk_sel, switching, fault}, exp);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    turbo_en       = 1'b1;
    need_slow      = 1'b0;
    lsclk_selected = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 25) fault_clr = 1'b1;
      if (c == 26) fault_clr = 1'b0;
      if (c == 39) lsclk_selected = 1'b1;
      if (c == 48) fault_clr = 1'b1;
      if (c == 49) fault_clr = 1'b0;
      if (c <= 16)      exp = 6'b001_110;
      else if (c <= 39) exp = 6'b011_011;
      else if (c <= 43) exp = 6'b100_001;
      else if (c <= 48) exp = 6'b000_001;
      else if (c == 49) exp = 6'b000_000;
      else              exp = 6'b001_110;
      vecs++;
      if ({state_o, hsclk_sel, switching, fault} !== exp) begin
        errs++;
        $display("FAIL timeout c%0d: got %b want %b", c, {state_o, hsclk_sel, switching, fault}, exp);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    turbo_en  = 1'b1;
    need_slow = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) need_slow = 1'b1;
      case (c)
        1, 2:    exp = 6'b001_110;
        3:       exp = 6'b011_010;
        default: exp = 6'b100_000;
      endcase
      vecs++;
      if ({state_o, hsclk_sel, switching, fault} !== exp) begin
        errs++;
        $display("FAIL abort c%0d: got %b want %b", c, {state_o, hsclk_sel, switching, fault}, exp);
      end
    end
    need_slow = 1'b0;
  endtask

  task automatic test_loss();
    go_hs();
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 2) hsclk_selected = 1'b0;
      if (k == 4) fault_clr = 1'b1;
      if (k == 5) begin
        fault_clr      = 1'b0;
        lsclk_selected = 1'b1;
      end
      if (k == 6) fault_clr = 1'b1;
      if (k == 7) fault_clr = 1'b0;
      if (k <= 4)      exp = 6'b010_100;
      else if (k == 5) exp = 6'b011_011;
      else if (k == 6) exp = 6'b100_001;
      else             exp = 6'b100_000;
      vecs++;
      if ({state_o, hsclk_sel, switching, fault} !== exp) begin
        errs++;
        $display("FAIL loss k%0d: got %b want %b", k, {state_o, hsclk_sel, switching, fault}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    turbo_en       = 1'b1;
    need_slow      = 1'b0;
    lsclk_selected = 1'b0;
    repeat (5) tick();
    exp = 6'b001_110;
    vecs++;
    if ({state_o, hsclk_sel, switching, fault} !== exp) begin
      errs++;
      $display("FAIL areset_pre: got %b want %b", {state_o, hsclk_sel, switching, fault}, exp);
    end
    #2;
    rst_b = 1'b0;
    #1;
    exp = 6'b000_000;
    vecs++;
    if ({state_o, hsclk_sel, switching, fault} !== exp) begin
      errs++;
      $display("FAIL areset_now: got %b want %b", {state_o, hsclk_sel, switching, fault}, exp);
    end
    tick();
    vecs++;
    if ({state_o, hsclk_sel, switching, fault} !== exp) begin
      errs++;
      $display("FAIL areset_held: got %b want %b", {state_o, hsclk_sel, switching, fault}, exp);
    end
    rst_b = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hs_entry();
    test_return_ls();
    test_timeout();
    test_abort();
    test_loss();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
